// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: snapshots a packed digit bus
// once per frame and drives one digit common at a time with dead-time between digits.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int DEAD   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lzb,
  output logic [DIGITS-1:0]     com_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame
);

  localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD - 1);
  localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         presc, presc_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*DIGITS-1:0]   dig_sh;
  logic [DIGITS-1:0]     dp_sh;
  logic                  lzb_sh;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            cur_nib;
  logic                  upper_zero;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  // State register with scan position and prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      presc <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      idx   <= idx_nxt;
    end
  end

  // Snapshot taken on the LOAD exit edge so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_sh <= '0;
      dp_sh  <= '0;
      lzb_sh <= 1'b0;
    end else if (state == LOAD && en) begin
      dig_sh <= digits;
      dp_sh  <= dp_mask;
      lzb_sh <= lzb;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        state_nxt = BLANK;
        presc_nxt = '0;
        idx_nxt   = '0;
      end
      BLANK: begin
        if (presc == DEAD_LAST) begin
          state_nxt = DRIVE;
          presc_nxt = '0;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      DRIVE: begin
        if (presc == DIV_LAST) begin
          presc_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = BLANK;
            idx_nxt   = idx + 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en && state != IDLE) begin
      state_nxt = IDLE;
      presc_nxt = '0;
      idx_nxt   = '0;
    end
  end

  // Digit i>0 blanks when lzb is set and it and every more significant nibble are zero.
  always_comb begin
    blank      = '0;
    upper_zero = lzb_sh;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (dig_sh[4*i +: 4] == 4'h0);
      blank[i]   = upper_zero;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) cur_nib = dig_sh[4*i +: 4];
    end
  end

  always_comb begin
    com_n = '1;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    frame = 1'b0;
    case (state)
      LOAD: frame = 1'b1;
      DRIVE: begin
        com_n[idx] = 1'b0;
        seg_n      = blank[idx] ? 7'h7F : hex_decode(cur_nib);
        dp_n       = ~dp_sh[idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=4, DEAD=2 (25-cycle frames).
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int DEAD   = 2;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lzb;
  logic [3:0]  com_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .digits  (digits),
    .dp_mask (dp_mask),
    .lzb     (lzb),
    .com_n   (com_n),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_com"},   7'(com_n), 7'hF);
    chk({tag, "_seg"},   seg_n,     7'h7F);
    chk({tag, "_dp"},    7'(dp_n),  7'h1);
    chk({tag, "_frame"}, 7'(frame), 7'h0);
  endtask

  // Next cycle must be LOAD: frame pulse with all outputs dark.
  task automatic step_load(input string tag);
    tick();
    chk({tag, "_frame"}, 7'(frame), 7'h1);
    chk({tag, "_com"},   7'(com_n), 7'hF);
  endtask

  // One digit slot: DEAD dark cycles then DIV driven cycles.
  task automatic slot(input string tag, input int i, input logic [6:0] s, input logic d);
    logic [3:0] exp_com;
    exp_com    = 4'hF;
    exp_com[i] = 1'b0;
    for (int k = 0; k < DEAD; k++) begin
      tick();
      chk_off({tag, "_dead"});
    end
    for (int k = 0; k < DIV; k++) begin
      tick();
      chk({tag, "_com"},   7'(com_n), 7'(exp_com));
      chk({tag, "_seg"},   seg_n,     s);
      chk({tag, "_dp"},    7'(dp_n),  7'(d));
      chk({tag, "_frame"}, 7'(frame), 7'h0);
    end
  endtask

  initial begin
    // Test 1: reset holds outputs dark even with en=1 and all-F digits
    reset_n = 1'b0;
    en      = 1'b1;
    digits  = 16'hFFFF;
    dp_mask = 4'hF;
    lzb     = 1'b0;
    #1;
    chk_off("rst_async");
    tick();
    tick();
    chk_off("rst_hold");
    reset_n = 1'b1;
    step_load("t1_first");

    // Test 2: captured at this LOAD exit
    digits  = 16'h1234;
    dp_mask = 4'b0100;
    lzb     = 1'b0;
    slot("t2_d0", 0, 7'h19, 1'b1);
    slot("t2_d1", 1, 7'h30, 1'b1);
    slot("t2_d2", 2, 7'h24, 1'b0);
    slot("t2_d3", 3, 7'h79, 1'b1);
    step_load("t2_period");

    // Test 3: digits change mid-frame, take effect next frame only
    slot("t3_d0", 0, 7'h19, 1'b1);
    slot("t3_d1", 1, 7'h30, 1'b1);
    digits = 16'h9876;
    slot("t3_d2", 2, 7'h24, 1'b0);
    slot("t3_d3", 3, 7'h79, 1'b1);
    step_load("t3_load");
    slot("t3_n0", 0, 7'h02, 1'b1);
    slot("t3_n1", 1, 7'h78, 1'b1);
    slot("t3_n2", 2, 7'h00, 1'b0);
    slot("t3_n3", 3, 7'h10, 1'b1);
    step_load("t3_load2");

    // Test 4: leading-zero blanking
    digits  = 16'h0005;
    dp_mask = 4'b0000;
    lzb     = 1'b1;
    slot("t4a_d0", 0, 7'h12, 1'b1);
    slot("t4a_d1", 1, 7'h7F, 1'b1);
    slot("t4a_d2", 2, 7'h7F, 1'b1);
    slot("t4a_d3", 3, 7'h7F, 1'b1);
    step_load("t4a_load");
    digits = 16'h0000;
    slot("t4b_d0", 0, 7'h40, 1'b1);
    slot("t4b_d1", 1, 7'h7F, 1'b1);
    slot("t4b_d2", 2, 7'h7F, 1'b1);
    slot("t4b_d3", 3, 7'h7F, 1'b1);
    step_load("t4b_load");
    digits = 16'h0105;
    slot("t4c_d0", 0, 7'h12, 1'b1);
    slot("t4c_d1", 1, 7'h40, 1'b1);
    slot("t4c_d2", 2, 7'h79, 1'b1);
    slot("t4c_d3", 3, 7'h7F, 1'b1);
    step_load("t4c_load");

    // Test 5: en dropped during digit-2 drive
    digits  = 16'h1234;
    dp_mask = 4'b0100;
    lzb     = 1'b0;
    slot("t5_d0", 0, 7'h19, 1'b1);
    slot("t5_d1", 1, 7'h30, 1'b1);
    tick();
    tick();
    tick();
    chk("t5_d2_com", 7'(com_n), 7'hB);
    chk("t5_d2_seg", seg_n,     7'h24);
    tick();
    en = 1'b0;
    tick();
    chk_off("t5_dark");
    tick();
    tick();
    chk_off("t5_idle");
    en = 1'b1;
    step_load("t5_reload");
    slot("t5_r0", 0, 7'h19, 1'b1);

    // Test 6: asynchronous reset mid-drive
    slot("t6_d1", 1, 7'h30, 1'b1);
    tick();
    tick();
    tick();
    chk("t6_pre_com", 7'(com_n), 7'hB);
    #2;
    reset_n = 1'b0;
    #1;
    chk_off("t6_async");
    #2;
    reset_n = 1'b1;
    step_load("t6_restart");
    slot("t6_r0", 0, 7'h19, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit seven-segment display, driven by the team's BCD/hex counter chain. It snapshots a packed digit bus once per frame and drives one digit common at a time. A blanking dead-time between digits suppresses ghosting. Segment decode is hex 0-F, with optional leading-zero blanking and per-digit decimal point.

Parameters:
DIGITS, 4, number of display digits (>=2)
DIV, 1000, clk cycles each digit is driven (>=1)
DEAD, 16, clk cycles all outputs are off between digits (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 = display dark
digits  input  4*DIGITS  packed nibbles; [3:0] = digit 0 (rightmost), [4*DIGITS-1:4*DIGITS-4] = most significant
dp_mask  input  DIGITS  bit i = 1 lights the decimal point of digit i
lzb  input  1  leading-zero blanking enable
com_n  output  DIGITS  digit commons, active low, at most one low
seg_n  output  7  segments {g,f,e,d,c,b,a}, active low
dp_n  output  1  decimal point, active low
frame  output  1  one-cycle pulse in the LOAD state

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, idx=0, prescaler=0, shadow regs=0; com_n=all 1, seg_n=7'h7F, dp_n=1, frame=0.
- Moore outputs: com_n, seg_n, dp_n and frame depend only on registered state. No combinational path from inputs to outputs.
- FSM states:
  - IDLE: outputs off. en=1 -> LOAD.
  - LOAD: exactly 1 cycle; frame=1; outputs off.
    - At exit, captures digits, dp_mask and lzb into shadow registers.
    - Sets idx=0 and prescaler=0; next state BLANK.
  - BLANK: outputs off for DEAD cycles; prescaler counts 0..DEAD-1. On the last cycle -> DRIVE and prescaler clears.
  - DRIVE: lasts DIV cycles; prescaler counts 0..DIV-1.
    - com_n[idx]=0, all other com_n bits 1.
    - seg_n = decode(shadow nibble idx), or 7'h7F if the digit is blanked.
    - dp_n = ~shadow_dp[idx].
    - On the last cycle: if idx==DIGITS-1 -> LOAD; else idx+1 -> BLANK.
- en=0 in any non-IDLE state: next state IDLE, prescaler and idx cleared, outputs off from the next cycle. Shadow registers hold their values.
- Re-enabling always starts at LOAD, so the first digit driven is idx 0.
- Frame period is DIGITS*(DEAD+DIV)+1 cycles, which is also the spacing between frame pulses.
- Snapshot rule: digits, dp_mask and lzb changes take effect only at the next LOAD; no tearing within a frame.
- Leading-zero blanking: digit i (i>0) is blanked when shadow lzb=1 and shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit still occupies its DRIVE slot with its common asserted, seg_n=7'h7F, and dp per dp_mask.
- Hex decode (seg_n, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Prescaler width is clog2(max(DIV,DEAD)); no wrap beyond its terminal count.
- Reset asserted mid-DRIVE: all outputs off immediately, without waiting for a clock edge.

Test Plan:
1. Reset with en=1 and digits=16'hFFFF -> com_n=4'hF, seg_n=7'h7F, dp_n=1, frame=0 while reset_n=0; first frame pulse occurs 1 cycle after release.
2. DIV=4, DEAD=2, digits=16'h1234, dp_mask=4'b0100, lzb=0, en=1 -> after frame: 2 off cycles, then 4 cycles of com_n=1110 with seg_n=19, dp_n=1.
   - Next slots in order: digit 1 shows 30; digit 2 shows 24 with dp_n=0; digit 3 shows 79.
   - Frame pulses are 25 cycles apart.
3. digits changed from 16'h1234 to 16'h9876 during the digit-1 slot -> digits 2 and 3 still show 24 and 79 this frame; the next frame shows 02, 78, 00, 10 for digits 0-3.
4. lzb=1: digits=16'h0005 -> digits 3, 2, 1 show seg_n=7F with commons still cycling, digit 0 shows 12.
   - digits=16'h0000 -> digit 0 shows 40.
   - digits=16'h0105 -> digit 1 shows 40, digit 3 is blank.
5. en dropped during the digit-2 DRIVE slot -> next cycle com_n=F and seg_n=7F. When en returns, LOAD and frame occur on the next cycle, then digit 0 is driven after DEAD cycles.
6. reset_n pulsed low between clock edges during DRIVE -> com_n=F immediately. After release, the sequence restarts from IDLE and LOAD with idx=0.
